// File: rtl/idex_stage_reg_if.sv
// ID/EX stage bundle: ID-side handshake and operands in, EX-side payload and
// regenerated control out. The stage uses 'slave'; the environment uses 'master'.
interface idex_stage_reg_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          flush;
    logic          loaduse;
    logic          id_valid;
    logic          id_ready;
    logic          ex_ready;
    logic          ex_valid;
    logic          busy;

    logic [DW-1:0] pc_id, busA_id, busB_id, hi_id, lo_id, cpr_id;
    logic [5:0]    op_id, func_id;
    logic [RW-1:0] rs_id, rt_id, rd_id, shamt_id;
    logic [15:0]   imm16_id;

    logic [DW-1:0] pc_ex, busA_ex, busB_ex, hi_ex, lo_ex, cpr_ex;
    logic [5:0]    op_ex, func_ex;
    logic [RW-1:0] rs_ex, rt_ex, rd_ex, shamt_ex;
    logic [15:0]   imm16_ex;

    logic [4:0]    alu_ctr;
    logic          ext_op, reg_dst, alu_src, mem_read, mem_write, reg_write;

    modport slave (
        input  flush, loaduse, id_valid, ex_ready,
        input  pc_id, busA_id, busB_id, hi_id, lo_id, cpr_id,
        input  op_id, func_id, rs_id, rt_id, rd_id, shamt_id, imm16_id,
        output id_ready, ex_valid, busy,
        output pc_ex, busA_ex, busB_ex, hi_ex, lo_ex, cpr_ex,
        output op_ex, func_ex, rs_ex, rt_ex, rd_ex, shamt_ex, imm16_ex,
        output alu_ctr, ext_op, reg_dst, alu_src, mem_read, mem_write, reg_write
    );

    modport master (
        output flush, loaduse, id_valid, ex_ready,
        output pc_id, busA_id, busB_id, hi_id, lo_id, cpr_id,
        output op_id, func_id, rs_id, rt_id, rd_id, shamt_id, imm16_id,
        input  id_ready, ex_valid, busy,
        input  pc_ex, busA_ex, busB_ex, hi_ex, lo_ex, cpr_ex,
        input  op_ex, func_ex, rs_ex, rt_ex, rd_ex, shamt_ex, imm16_ex,
        input  alu_ctr, ext_op, reg_dst, alu_src, mem_read, mem_write, reg_write
    );
endinterface

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with valid/ready handshake, flush, load-use bubbles
// and a MULT/DIV occupancy countdown. State updates on the falling edge of clk.
module idex_stage_reg #(
    parameter int DW            = 32,
    parameter int RW            = 5,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    idex_stage_reg_if.slave  bus
);
    localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {IDLE, FULL, MDWAIT} state_t;

    typedef enum logic [4:0] {
        ALU_NOP  = 5'd0,  ALU_ADDU = 5'd1,  ALU_SUBU  = 5'd2,  ALU_AND  = 5'd3,
        ALU_OR   = 5'd4,  ALU_XOR  = 5'd5,  ALU_NOR   = 5'd6,  ALU_SLT  = 5'd7,
        ALU_SLTU = 5'd8,  ALU_SLL  = 5'd9,  ALU_SRL   = 5'd10, ALU_SRA  = 5'd11,
        ALU_LUI  = 5'd12, ALU_ADD  = 5'd13, ALU_SUB   = 5'd14, ALU_MULT = 5'd15,
        ALU_MULTU = 5'd16, ALU_DIV = 5'd17, ALU_DIVU  = 5'd18
    } alu_op_t;

    typedef struct packed {
        logic [DW-1:0] pc, busA, busB, hi, lo, cpr;
        logic [5:0]    op, func;
        logic [RW-1:0] rs, rt, rd, shamt;
        logic [15:0]   imm16;
    } payload_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    payload_t        pay_q, pay_d;
    logic            load, accept, is_muldiv, ex_valid, busy;

    assign ex_valid     = (state_q != IDLE);
    assign busy         = (state_q == MDWAIT);
    assign bus.ex_valid = ex_valid;
    assign bus.busy     = busy;
    assign bus.id_ready = !busy && !bus.loaduse && (!ex_valid || bus.ex_ready);
    assign accept       = bus.id_valid && bus.id_ready;
    assign is_muldiv    = (bus.op_id == OP_RTYPE) && (bus.func_id[5:2] == 4'b0110);

    assign pay_d = '{pc: bus.pc_id, busA: bus.busA_id, busB: bus.busB_id,
                     hi: bus.hi_id, lo: bus.lo_id, cpr: bus.cpr_id,
                     op: bus.op_id, func: bus.func_id, rs: bus.rs_id,
                     rt: bus.rt_id, rd: bus.rd_id, shamt: bus.shamt_id,
                     imm16: bus.imm16_id};

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load    = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
            count_d = '0;
        end else if (state_q == MDWAIT) begin
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) state_d = FULL;
        end else if (bus.loaduse && (!ex_valid || bus.ex_ready)) begin
            state_d = IDLE;
        end else if (ex_valid && !bus.ex_ready) begin
            state_d = state_q;  // EX stalled: hold everything
        end else if (accept) begin
            load = 1'b1;
            if (is_muldiv && MULDIV_CYCLES > 1) begin
                state_d = MDWAIT;
                count_d = CW'(MULDIV_CYCLES - 1);
            end else begin
                state_d = FULL;
            end
        end else begin
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // NOTE: the payload is reset too, because EX observes it directly and must see zeros out of reset.
    always_ff @(negedge clk) begin
        if (rst)       pay_q <= '0;
        else if (load) pay_q <= pay_d;
    end

    assign bus.pc_ex    = pay_q.pc;     assign bus.busA_ex  = pay_q.busA;
    assign bus.busB_ex  = pay_q.busB;   assign bus.hi_ex    = pay_q.hi;
    assign bus.lo_ex    = pay_q.lo;     assign bus.cpr_ex   = pay_q.cpr;
    assign bus.op_ex    = pay_q.op;     assign bus.func_ex  = pay_q.func;
    assign bus.rs_ex    = pay_q.rs;     assign bus.rt_ex    = pay_q.rt;
    assign bus.rd_ex    = pay_q.rd;     assign bus.shamt_ex = pay_q.shamt;
    assign bus.imm16_ex = pay_q.imm16;

    alu_op_t alu;
    logic    ext, dst, src, mrd, mwr, rwr;

    always_comb begin
        alu = ALU_NOP;
        ext = 1'b0; dst = 1'b0; src = 1'b0; mrd = 1'b0; mwr = 1'b0; rwr = 1'b0;
        if (pay_q.op == OP_RTYPE) begin
            dst = 1'b1;
            rwr = 1'b1;
            case (pay_q.func)
                6'b100000: alu = ALU_ADD;
                6'b100001: alu = ALU_ADDU;
                6'b100010: alu = ALU_SUB;
                6'b100011: alu = ALU_SUBU;
                6'b100100: alu = ALU_AND;
                6'b100101: alu = ALU_OR;
                6'b100110: alu = ALU_XOR;
                6'b100111: alu = ALU_NOR;
                6'b101010: alu = ALU_SLT;
                6'b101011: alu = ALU_SLTU;
                6'b000000: alu = ALU_SLL;
                6'b000010: alu = ALU_SRL;
                6'b000011: alu = ALU_SRA;
                6'b011000: begin alu = ALU_MULT;  rwr = 1'b0; end  // results go to hi/lo
                6'b011001: begin alu = ALU_MULTU; rwr = 1'b0; end
                6'b011010: begin alu = ALU_DIV;   rwr = 1'b0; end
                6'b011011: begin alu = ALU_DIVU;  rwr = 1'b0; end
                default:   rwr = 1'b0;
            endcase
        end else begin
            case (pay_q.op)
                OP_ADDIU: begin alu = ALU_ADDU; ext = 1'b1; src = 1'b1; rwr = 1'b1; end
                OP_SLTI:  begin alu = ALU_SLT;  ext = 1'b1; src = 1'b1; rwr = 1'b1; end
                OP_SLTIU: begin alu = ALU_SLTU; ext = 1'b1; src = 1'b1; rwr = 1'b1; end
                OP_ANDI:  begin alu = ALU_AND;  src = 1'b1; rwr = 1'b1; end
                OP_ORI:   begin alu = ALU_OR;   src = 1'b1; rwr = 1'b1; end
                OP_XORI:  begin alu = ALU_XOR;  src = 1'b1; rwr = 1'b1; end
                OP_LUI:   begin alu = ALU_LUI;  src = 1'b1; rwr = 1'b1; end
                OP_LW:    begin alu = ALU_ADDU; ext = 1'b1; src = 1'b1; mrd = 1'b1; rwr = 1'b1; end
                OP_SW:    begin alu = ALU_ADDU; ext = 1'b1; src = 1'b1; mwr = 1'b1; end
                default:  alu = ALU_NOP;
            endcase
        end
    end

    // Bubbles must never drive memory or register-file writes.
    assign bus.alu_ctr   = ex_valid ? alu : ALU_NOP;
    assign bus.ext_op    = ex_valid & ext;
    assign bus.reg_dst   = ex_valid & dst;
    assign bus.alu_src   = ex_valid & src;
    assign bus.mem_read  = ex_valid & mrd;
    assign bus.mem_write = ex_valid & mwr;
    assign bus.reg_write = ex_valid & rwr;
endmodule
